// File: rtl/calc_sched.sv
// calc_sched: K-dimension tile-loop scheduler for the bit-serial calc unit.
// It accepts one tile command, prefetches the first A tile and S weight word,
// starts the calc unit once, then follows its mod-N_SLICES slice counter. The
// next tile is prefetched on the last slice, and the result is handed
// downstream with a valid/ready handshake.
module calc_sched #(
  parameter int ADDR_W   = 10,
  parameter int LEN_W    = 8,
  parameter int N_SLICES = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_a_base,
  input  logic [ADDR_W-1:0] cmd_s_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              abort,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  output logic              s_rd_en,
  output logic [ADDR_W-1:0] s_rd_addr,
  output logic              calc_start,
  output logic [2:0]        slice_idx,
  output logic [LEN_W-1:0]  tile_idx,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFETCH,
    S_RUN,
    S_WB,
    S_FIN
  } state_t;

  localparam logic [2:0] LAST_SLICE = 3'(N_SLICES - 1);

  state_t            state_q, state_nx;
  logic [ADDR_W-1:0] a_base_q, s_base_q, a_base_nx, s_base_nx;
  logic [LEN_W-1:0]  len_q, len_nx;

  // Next-cycle values of the registered outputs.
  logic              a_rd_en_nx, s_rd_en_nx, calc_start_nx;
  logic [ADDR_W-1:0] a_rd_addr_nx, s_rd_addr_nx;
  logic [2:0]        slice_nx;
  logic [LEN_W-1:0]  tile_nx;
  logic              acc_clr_nx, acc_en_nx, out_valid_nx, done_nx;

  logic              last_tile;
  logic [LEN_W-1:0]  tile_p1;
  logic [ADDR_W-1:0] tile_off;

  assign last_tile = (tile_idx == (len_q - LEN_W'(1)));
  assign tile_p1   = tile_idx + LEN_W'(1);
  assign tile_off  = ADDR_W'(tile_p1);

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

  // Next state and next registered-output values; abort overrides everything.
  always_comb begin
    state_nx      = state_q;
    a_base_nx     = a_base_q;
    s_base_nx     = s_base_q;
    len_nx        = len_q;
    a_rd_en_nx    = 1'b0;
    s_rd_en_nx    = 1'b0;
    a_rd_addr_nx  = '0;
    s_rd_addr_nx  = '0;
    calc_start_nx = 1'b0;
    slice_nx      = slice_idx;
    tile_nx       = tile_idx;
    acc_clr_nx    = 1'b0;
    acc_en_nx     = 1'b0;
    out_valid_nx  = 1'b0;
    done_nx       = 1'b0;

    case (state_q)
      S_IDLE: begin
        slice_nx = '0;
        tile_nx  = '0;
        if (cmd_valid && !abort) begin
          a_base_nx = cmd_a_base;
          s_base_nx = cmd_s_base;
          len_nx    = cmd_len;
          if (cmd_len == '0) begin
            state_nx = S_FIN;
            done_nx  = 1'b1;
          end else begin
            state_nx      = S_PREFETCH;
            a_rd_en_nx    = 1'b1;
            s_rd_en_nx    = 1'b1;
            a_rd_addr_nx  = cmd_a_base;
            s_rd_addr_nx  = cmd_s_base;
            calc_start_nx = 1'b1;
          end
        end
      end
      S_PREFETCH: begin
        state_nx   = S_RUN;
        slice_nx   = '0;
        tile_nx    = '0;
        acc_en_nx  = 1'b1;
        acc_clr_nx = 1'b1;
      end
      S_RUN: begin
        if (slice_idx == LAST_SLICE) begin
          if (last_tile) begin
            state_nx     = S_WB;
            out_valid_nx = 1'b1;
          end else begin
            slice_nx  = '0;
            tile_nx   = tile_p1;
            acc_en_nx = 1'b1;
          end
        end else begin
          slice_nx  = slice_idx + 3'd1;
          acc_en_nx = 1'b1;
          // Prefetch on the last slice so the next tile's operands land on slice 0.
          if ((slice_idx == (LAST_SLICE - 3'd1)) && !last_tile) begin
            a_rd_en_nx   = 1'b1;
            s_rd_en_nx   = 1'b1;
            a_rd_addr_nx = a_base_q + tile_off;
            s_rd_addr_nx = s_base_q + tile_off;
          end
        end
      end
      S_WB: begin
        if (out_ready) begin
          state_nx = S_FIN;
          done_nx  = 1'b1;
        end else begin
          out_valid_nx = 1'b1;
        end
      end
      S_FIN: begin
        state_nx = S_IDLE;
        slice_nx = '0;
        tile_nx  = '0;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_nx      = S_IDLE;
      a_rd_en_nx    = 1'b0;
      s_rd_en_nx    = 1'b0;
      a_rd_addr_nx  = '0;
      s_rd_addr_nx  = '0;
      calc_start_nx = 1'b0;
      slice_nx      = '0;
      tile_nx       = '0;
      acc_clr_nx    = 1'b0;
      acc_en_nx     = 1'b0;
      out_valid_nx  = 1'b0;
      done_nx       = 1'b0;
    end
  end

  // State, latched command and registered outputs; async reset clears all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_base_q   <= '0;
      s_base_q   <= '0;
      len_q      <= '0;
      a_rd_en    <= 1'b0;
      s_rd_en    <= 1'b0;
      a_rd_addr  <= '0;
      s_rd_addr  <= '0;
      calc_start <= 1'b0;
      slice_idx  <= '0;
      tile_idx   <= '0;
      acc_clr    <= 1'b0;
      acc_en     <= 1'b0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_nx;
      a_base_q   <= a_base_nx;
      s_base_q   <= s_base_nx;
      len_q      <= len_nx;
      a_rd_en    <= a_rd_en_nx;
      s_rd_en    <= s_rd_en_nx;
      a_rd_addr  <= a_rd_addr_nx;
      s_rd_addr  <= s_rd_addr_nx;
      calc_start <= calc_start_nx;
      slice_idx  <= slice_nx;
      tile_idx   <= tile_nx;
      acc_clr    <= acc_clr_nx;
      acc_en     <= acc_en_nx;
      out_valid  <= out_valid_nx;
      done       <= done_nx;
    end
  end

endmodule

// File: tb/tb_calc_sched.sv
// tb_calc_sched: directed stimulus for calc_sched with a cycle-level schedule
// model (accept cycle, tile count, handshake cycle) checked every cycle, plus
// literal expectations taken from the tile-loop timing.
module tb_calc_sched;

  localparam int ADDR_W = 10;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [ADDR_W-1:0] cmd_a_base = '0;
  logic [ADDR_W-1:0] cmd_s_base = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              abort = 1'b0;
  logic              out_ready = 1'b1;
  logic              cmd_ready, a_rd_en, s_rd_en, calc_start;
  logic [ADDR_W-1:0] a_rd_addr, s_rd_addr;
  logic [2:0]        slice_idx;
  logic [LEN_W-1:0]  tile_idx;
  logic              acc_clr, acc_en, out_valid, busy, done;

  calc_sched #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .N_SLICES(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a_base(cmd_a_base), .cmd_s_base(cmd_s_base), .cmd_len(cmd_len),
    .abort(abort),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
    .s_rd_en(s_rd_en), .s_rd_addr(s_rd_addr),
    .calc_start(calc_start), .slice_idx(slice_idx), .tile_idx(tile_idx),
    .acc_clr(acc_clr), .acc_en(acc_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- schedule model ----------------
  typedef enum int {P_IDLE, P_PRE, P_RUN, P_WB, P_FIN} ph_t;

  bit  m_active = 1'b0;
  int  m_c = 0, m_len = 0, m_a = 0, m_s = 0, m_hs = -1;
  int  mk, j, sl, tl, ea, es;
  ph_t mph, eph;
  logic e_rd, e_start, e_clr, e_en, e_ov, e_done;

  function automatic ph_t phase_at(input int k);
    int d;
    d = k - m_c;
    if (!m_active || d < 1) return P_IDLE;
    if (m_len == 0) return (d == 1) ? P_FIN : P_IDLE;
    if (d == 1) return P_PRE;
    if (d <= 1 + 5 * m_len) return P_RUN;
    if (m_hs < 0 || k <= m_hs) return P_WB;
    if (k == m_hs + 1) return P_FIN;
    return P_IDLE;
  endfunction

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 1'b0;
    end else begin
      #1;
      mk  = cyc - 1;
      mph = phase_at(mk);
      if (mph == P_IDLE) begin
        m_active = 1'b0;
        if (cmd_valid && !abort) begin
          m_active = 1'b1;
          m_c   = mk;
          m_len = int'(cmd_len);
          m_a   = int'(cmd_a_base);
          m_s   = int'(cmd_s_base);
          m_hs  = -1;
        end
      end else if (abort) begin
        m_active = 1'b0;
      end else if (mph == P_WB && out_ready && m_hs < 0) begin
        m_hs = mk;
      end

      eph = phase_at(cyc);
      e_rd = 1'b0; e_start = 1'b0; e_clr = 1'b0; e_en = 1'b0; e_ov = 1'b0; e_done = 1'b0;
      ea = 0; es = 0; sl = 0; tl = 0;
      case (eph)
        P_PRE: begin
          e_rd = 1'b1; e_start = 1'b1; ea = m_a; es = m_s;
        end
        P_RUN: begin
          j  = cyc - m_c - 2;
          sl = j % 5;
          tl = j / 5;
          e_en  = 1'b1;
          e_clr = (j == 0);
          if (sl == 4 && tl < m_len - 1) begin
            e_rd = 1'b1;
            ea = (m_a + tl + 1) % (1 << ADDR_W);
            es = (m_s + tl + 1) % (1 << ADDR_W);
          end
        end
        P_WB:    e_ov = 1'b1;
        P_FIN:   e_done = 1'b1;
        default: ;
      endcase
      chk("cmp.cmd_ready", 32'(cmd_ready), 32'(eph == P_IDLE));
      chk("cmp.busy", 32'(busy), 32'(eph != P_IDLE));
      chk("cmp.a_rd_en", 32'(a_rd_en), 32'(e_rd));
      chk("cmp.s_rd_en", 32'(s_rd_en), 32'(e_rd));
      chk("cmp.calc_start", 32'(calc_start), 32'(e_start));
      chk("cmp.acc_en", 32'(acc_en), 32'(e_en));
      chk("cmp.acc_clr", 32'(acc_clr), 32'(e_clr));
      chk("cmp.out_valid", 32'(out_valid), 32'(e_ov));
      chk("cmp.done", 32'(done), 32'(e_done));
      if (e_rd) begin
        chk("cmp.a_rd_addr", 32'(a_rd_addr), 32'(ea));
        chk("cmp.s_rd_addr", 32'(s_rd_addr), 32'(es));
      end
      if (eph == P_PRE || eph == P_RUN) begin
        chk("cmp.slice_idx", 32'(slice_idx), 32'(sl));
        chk("cmp.tile_idx", 32'(tile_idx), 32'(tl));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic at(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(cmd_ready), 32'd1);
  endtask

  // Drives a command for one cycle starting at the current negedge; returns the accept cycle.
  task automatic issue(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] s,
                       input logic [LEN_W-1:0] len, output int c);
    cmd_valid  = 1'b1;
    cmd_a_base = a;
    cmd_s_base = s;
    cmd_len    = len;
    c = cyc;
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_a_base = 10'h155;
    cmd_s_base = 10'h2AA;
    cmd_len    = 8'd7;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".a_rd_en"}, 32'(a_rd_en), 32'd0);
    chk({tag, ".s_rd_en"}, 32'(s_rd_en), 32'd0);
    chk({tag, ".a_rd_addr"}, 32'(a_rd_addr), 32'd0);
    chk({tag, ".s_rd_addr"}, 32'(s_rd_addr), 32'd0);
    chk({tag, ".calc_start"}, 32'(calc_start), 32'd0);
    chk({tag, ".slice_idx"}, 32'(slice_idx), 32'd0);
    chk({tag, ".tile_idx"}, 32'(tile_idx), 32'd0);
    chk({tag, ".acc"}, 32'({acc_clr, acc_en}), 32'd0);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    @(negedge clk);
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single tile
    wait_idle();
    issue(10'h010, 10'h020, 8'd1, c);
    at(c + 1);
    chk("t1.a_rd_en", 32'(a_rd_en), 32'd1);
    chk("t1.a_rd_addr", 32'(a_rd_addr), 32'h010);
    chk("t1.s_rd_addr", 32'(s_rd_addr), 32'h020);
    chk("t1.calc_start", 32'(calc_start), 32'd1);
    at(c + 2);
    chk("t1.acc_clr", 32'(acc_clr), 32'd1);
    chk("t1.slice0", 32'(slice_idx), 32'd0);
    at(c + 3);
    chk("t1.acc_clr_off", 32'(acc_clr), 32'd0);
    at(c + 6);
    chk("t1.slice4", 32'(slice_idx), 32'd4);
    chk("t1.no_read", 32'(a_rd_en), 32'd0);
    at(c + 7);
    chk("t1.out_valid", 32'(out_valid), 32'd1);
    at(c + 8);
    chk("t1.done", 32'(done), 32'd1);
    at(c + 9);
    chk("t1.ready_again", 32'(cmd_ready), 32'd1);

    // Three tiles
    wait_idle();
    issue(10'h100, 10'h200, 8'd3, c);
    at(c + 6);
    chk("t3.rd1_en", 32'(a_rd_en), 32'd1);
    chk("t3.rd1_addr", 32'(a_rd_addr), 32'h101);
    at(c + 7);
    chk("t3.tile1", 32'(tile_idx), 32'd1);
    at(c + 11);
    chk("t3.rd2_addr", 32'(s_rd_addr), 32'h202);
    at(c + 12);
    chk("t3.tile2", 32'(tile_idx), 32'd2);
    at(c + 16);
    chk("t3.no_ov_yet", 32'(out_valid), 32'd0);
    at(c + 17);
    chk("t3.out_valid", 32'(out_valid), 32'd1);

    // Backpressure
    wait_idle();
    out_ready = 1'b0;
    issue(10'h040, 10'h050, 8'd1, c);
    at(c + 12);
    chk("bp.out_valid", 32'(out_valid), 32'd1);
    chk("bp.acc_en", 32'(acc_en), 32'd0);
    chk("bp.a_rd_en", 32'(a_rd_en), 32'd0);
    at(c + 16);
    chk("bp.out_valid_hold", 32'(out_valid), 32'd1);
    at(c + 17);
    out_ready = 1'b1;
    at(c + 18);
    chk("bp.done", 32'(done), 32'd1);
    chk("bp.ov_drop", 32'(out_valid), 32'd0);

    // Address wrap
    wait_idle();
    issue(10'h3FF, 10'h3FE, 8'd2, c);
    at(c + 1);
    chk("wrap.rd0", 32'(a_rd_addr), 32'h3FF);
    at(c + 6);
    chk("wrap.a_rd1", 32'(a_rd_addr), 32'h000);
    chk("wrap.s_rd1", 32'(s_rd_addr), 32'h3FF);

    // Zero length
    wait_idle();
    issue(10'h0AA, 10'h0BB, 8'd0, c);
    at(c + 1);
    chk("z.done", 32'(done), 32'd1);
    chk("z.no_read", 32'(a_rd_en), 32'd0);
    at(c + 2);
    chk("z.idle", 32'(cmd_ready), 32'd1);

    // Abort mid-run at tile 1 slice 2
    wait_idle();
    issue(10'h000, 10'h000, 8'd3, c);
    at(c + 9);
    chk("ab.slice", 32'(slice_idx), 32'd2);
    chk("ab.tile", 32'(tile_idx), 32'd1);
    abort = 1'b1;
    at(c + 10);
    abort = 1'b0;
    chk("ab.idle", 32'(cmd_ready), 32'd1);
    chk("ab.acc_en", 32'(acc_en), 32'd0);
    at(c + 20);
    chk("ab.still_idle", 32'(busy), 32'd0);

    // Abort with cmd_valid in IDLE
    wait_idle();
    cmd_valid = 1'b1; abort = 1'b1; cmd_len = 8'd1;
    @(negedge clk);
    cmd_valid = 1'b0; abort = 1'b0;
    chk("abi.not_accepted", 32'(cmd_ready), 32'd1);
    chk("abi.no_start", 32'(calc_start), 32'd0);

    // Abort with out_ready in WB
    wait_idle();
    out_ready = 1'b0;
    issue(10'h011, 10'h022, 8'd1, c);
    at(c + 7);
    chk("abw.out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    abort = 1'b1;
    at(c + 8);
    abort = 1'b0;
    chk("abw.no_done", 32'(done), 32'd0);
    chk("abw.idle", 32'(cmd_ready), 32'd1);

    // Async reset mid-run, then a fresh command with nominal timing
    wait_idle();
    issue(10'h030, 10'h031, 8'd3, c);
    at(c + 8);
    #1 rst_n = 1'b0;
    #1 check_reset("arst");
    #1 rst_n = 1'b1;
    @(negedge clk);
    wait_idle();
    issue(10'h010, 10'h020, 8'd1, c);
    at(c + 1);
    chk("post.a_rd_addr", 32'(a_rd_addr), 32'h010);
    at(c + 7);
    chk("post.out_valid", 32'(out_valid), 32'd1);
    at(c + 8);
    chk("post.done", 32'(done), 32'd1);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
